// File: rtl/cs_result_collector.sv
// Result collector for the sliding-window CS: drops warm-up outputs, buffers one Y per
// window update in a FIFO and serves it on valid/ready. Optional drop counter: CS_COLLECT_STATS_EN.
module cs_result_collector #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned WARMUP = 9,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              sync_clr,
  input  logic [DATA_W-1:0] y_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned WARM_W = $clog2(WARMUP + 1);
  localparam int unsigned LVL_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [LVL_W-1:0]  level_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d, overflow_d;
  logic              full, pop, push, drop;

  // Next-state logic; out_data is precomputed so the head is a flop, not a memory read.
  always_comb begin
    full        = (level == LVL_W'(DEPTH));
    pop         = out_valid && out_ready;
    push        = pend_q && (!full || pop);
    drop        = pend_q && full && !pop;
    rd_ptr_inc  = rd_ptr_q + ADDR_W'(1);
    warm_cnt_d  = warm_cnt_q;
    pend_d      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level;
    out_data_d  = out_data;
    overflow_d  = overflow;
    if (sync_clr) begin
      warm_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (sample_en && (warm_cnt_q != WARM_W'(WARMUP)))
        warm_cnt_d = warm_cnt_q + WARM_W'(1);
      pend_d = sample_en && (warm_cnt_q >= WARM_W'(WARMUP - 1));
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_inc;
      if (push && !pop)      level_d = level + LVL_W'(1);
      else if (pop && !push) level_d = level - LVL_W'(1);
      if (push && ((level == '0) || (pop && (level == LVL_W'(1)))))
        out_data_d = y_in;
      else if (pop && (level > LVL_W'(1)))
        out_data_d = mem[rd_ptr_inc];
      if (drop) overflow_d = 1'b1;
    end
    out_valid_d = (level_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt_q <= '0;
      pend_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level      <= level_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      overflow   <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (!sync_clr && push) mem[wr_ptr_q] <= y_in;
  end

`ifdef CS_COLLECT_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (sync_clr)
      drop_cnt_d = '0;
    else if (drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cs_result_collector.sv
// Directed self-checking bench for cs_result_collector.
module tb_cs_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0;
  logic        sync_clr = 1'b0;
  logic [9:0]  y_in = '0;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef CS_COLLECT_STATS_EN
  localparam int unsigned DROP_EXP = 4;
`else
  localparam int unsigned DROP_EXP = 0;
`endif

  cs_result_collector dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .sync_clr(sync_clr),
    .y_in(y_in), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Warm-up: 12 sample edges with y_in = index, plus one trailing edge
    for (int i = 0; i < 12; i++) begin
      sample_en = 1'b1;
      y_in = 10'(i);
      step();
      if (i == 8) check("warm_e9_level", 32'(level), 0);
      if (i == 9) begin
        check("warm_e10_valid", 32'(out_valid), 1);
        check("warm_e10_data", 32'(out_data), 9);
      end
    end
    sample_en = 1'b0;
    y_in = 10'd12;
    step();
    check("warm_level4", 32'(level), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("warm_pop_data", 32'(out_data), 32'(9 + i));
      step();
    end
    check("warm_empty", 32'(out_valid), 0);
    check("warm_hold", 32'(out_data), 12);

    // Constant stream: window full, every sample yields 225
    out_ready = 1'b0;
    y_in = 10'd225;
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1;
      step();
    end
    sample_en = 1'b0;
    step();
    check("const_level", 32'(level), 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("const_data", 32'(out_data), 225);
      step();
    end
    check("const_empty", 32'(level), 0);

    // Backpressure overflow after a fresh warm-up
    out_ready = 1'b0;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample_en = 1'b1;
      y_in = 10'(100 + i);
      step();
    end
    sample_en = 1'b0;
    step();
    check("ovf_level", 32'(level), 8);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drop", 32'(drop_cnt), DROP_EXP);
    check("ovf_head", 32'(out_data), 109);

    // Full with a simultaneous pop: no drop
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 17; i++) begin
      sample_en = 1'b1;
      y_in = 10'(200 + i);
      step();
    end
    sample_en = 1'b0;
    y_in = 10'd217;
    check("fp_level_full", 32'(level), 8);
    check("fp_head", 32'(out_data), 209);
    out_ready = 1'b1;
    step();
    check("fp_level_kept", 32'(level), 8);
    check("fp_no_ovf", 32'(overflow), 0);
    check("fp_no_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      check("fp_order", 32'(out_data), 32'(210 + i));
      step();
    end
    check("fp_empty", 32'(out_valid), 0);

    // sync_clr at level 5 restarts warm-up
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1;
      y_in = 10'(50 + i);
      step();
    end
    sample_en = 1'b0;
    step();
    check("sc_level5", 32'(level), 5);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("sc_level0", 32'(level), 0);
    check("sc_valid", 32'(out_valid), 0);
    check("sc_ovf", 32'(overflow), 0);
    for (int i = 0; i < 9; i++) begin
      sample_en = 1'b1;
      y_in = 10'(300 + i);
      step();
      check("sc_no_push", 32'(level), 0);
    end
    sample_en = 1'b0;
    step();
    check("sc_push9", 32'(level), 1);
    check("sc_push9_data", 32'(out_data), 308);

    // Async reset mid-stream with 3 entries stored
    for (int i = 0; i < 2; i++) begin
      sample_en = 1'b1;
      y_in = 10'(400 + i);
      step();
    end
    sample_en = 1'b0;
    step();
    check("ar_level3", 32'(level), 3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 0);
    check("ar_level", 32'(level), 0);
    check("ar_ovf", 32'(overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1;
      step();
    end
    sample_en = 1'b0;
    step();
    check("ar_no_push", 32'(level), 0);

    // Pop request on empty FIFO is ignored while a push lands
    out_ready = 1'b1;
    sample_en = 1'b1;
    y_in = 10'd77;
    step();
    sample_en = 1'b0;
    check("emp_pend_level", 32'(level), 0);
    out_ready = 1'b0;
    step();
    check("emp_push_level", 32'(level), 1);
    check("emp_push_data", 32'(out_data), 77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_result_collector.md
Name: cs_result_collector

Overview:
- Receiving end of the sliding-window computational system (CS). Sits after the CS datapath.
- Tracks how full the 9-sample window is and discards warm-up outputs, where the window is not yet full.
- Captures one Y result per window update and buffers results in a small FIFO.
- Presents results downstream on a valid/ready handshake, with overflow reporting.

Parameters:
- DATA_W, 10, width of Y result and out_data
- WARMUP, 9, number of samples loaded before the CS window is full
- DEPTH, 8, FIFO entries; power of 2, minimum 2
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  rising-edge clock, shared with CS
- reset  in  1  asynchronous, active-low reset; 0 clears all state
- sample_en  in  1  1 = CS loads a new X sample on this clock edge
- sync_clr  in  1  synchronous clear, asserted together with the CS synchronous reset
- y_in  in  DATA_W  CS Y output; combinational from the CS window registers
- out_data  out  DATA_W  FIFO head result
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts out_data
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky flag: a result was dropped because the FIFO was full
- drop_cnt  out  16  dropped-result counter (see Optional Feature)

Behaviour:
- Reset (reset=0, async): warm_cnt=0, pend=0, FIFO empty, out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0.
- Warm-up counter warm_cnt (width for 0..WARMUP):
  - increments on each edge with sample_en=1;
  - saturates at WARMUP.
- Capture pending:
  - pend <= sample_en && (warm_cnt >= WARMUP-1), registered;
  - pend=1 means y_in in the current cycle reflects a full, freshly updated window.
- Push:
  - on an edge with pend=1, y_in is written to the FIFO tail;
  - exactly one capture per window update, none during warm-up.
- Latency: sample edge t → capture at edge t+1 → out_valid high after edge t+1 when the FIFO was empty. No bypass path.
- Pop: an edge with out_valid && out_ready removes the head; out_data shows the next entry after that edge.
- Full (level==DEPTH):
  - push without pop: result dropped, FIFO unchanged, overflow <= 1;
  - push with pop in the same cycle: both occur, no drop, level stays DEPTH.
- Empty: pop is ignored (out_valid=0); push and no pop gives level 1.
- Simultaneous push and pop at any level: level unchanged.
- Pointers: rd/wr pointers wrap modulo DEPTH. level is a separate counter, not pointer-derived.
- out_data holds its value while out_valid=0, and while out_valid=1 && out_ready=0.
- sync_clr=1 (highest synchronous priority): warm_cnt=0, pend=0, FIFO emptied, overflow=0, drop_cnt=0 on that edge. Concurrent push and pop are ignored.
- Async reset mid-stream: all state clears immediately. After reset release, the next WARMUP sample_en edges produce no capture.
- Arithmetic: no arithmetic on data; y_in is stored verbatim.

Optional Feature:
- Macro CS_COLLECT_STATS_EN.
- Defined: drop_cnt increments on every dropped push, saturates at 16'hFFFF, and is cleared by reset or sync_clr.
- Undefined: drop_cnt is tied to 16'd0 and no counter logic is present; all other behaviour is identical.

Test Plan:
- Reset: reset=0 mid-operation with 3 entries stored → out_valid=0, level=0, overflow=0 immediately. After release, 8 sample_en cycles → level stays 0.
- Warm-up: reset released, out_ready=0, y_in=cycle index, sample_en=1 for 12 edges → exactly 4 entries. First entry = y_in in the cycle after the 9th sample edge; out_valid rises 1 cycle after that.
- Constant stream: CS driven with X=8'd100, y_in from CS → first captured value 10'd225. All later values 225 while X stays constant.
- Backpressure overflow: out_ready=0, 20 sample edges → 12 captures, level=8, overflow=1, drop_cnt=4 (macro on) or 0 (macro off).
- Full with pop: level=8, out_ready=1 while a capture is pending → no drop, level stays 8, overflow stays 0. Popped values appear in push order.
- sync_clr: sync_clr=1 for one edge at level=5 → level=0, out_valid=0, overflow=0. Next 8 sample edges → no push; 9th sample edge → push one edge later.
